// File: rtl/filtr_pkg.sv
// rtl/filtr_pkg.sv - shared constants and helpers for the filter datapath
package filtr_pkg;

    localparam int FILTR_DATA_SIZE = 24;
    localparam int SAMPLE_CNT_SIZE = 16;
    localparam int SAT_ABS_W       = 64;

    // Absolute value of a sign-extended sample of the given width.
    // The most negative value has no positive counterpart, so it
    // saturates to the largest positive value of that width.
    function automatic logic [SAT_ABS_W-1:0] sat_abs(
        input logic signed [SAT_ABS_W-1:0] data,
        input int unsigned                 width
    );
        logic signed [SAT_ABS_W-1:0] most_neg;
        most_neg = -(64'sd1 <<< (width - 1));
        if (data == most_neg)
            sat_abs = ~most_neg;
        else if (data < 0)
            sat_abs = -data;
        else
            sat_abs = data;
    endfunction

endpackage

// File: rtl/filtr_capture_mem.sv
// rtl/filtr_capture_mem.sv - simple dual-port sample RAM with registered read
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset (read register only)
//   wr_en/wr_addr/wr_data  synchronous write port
//   rd_en/rd_addr       read request; rd_data updates on the following edge
//   rd_data             registered read word, holds when rd_en is low
module filtr_capture_mem #(
    parameter  int DATA_SIZE = 24,
    parameter  int DEPTH     = 64,
    localparam int ADDR_SIZE = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output logic [DATA_SIZE-1:0] rd_data
);

    logic [DATA_SIZE-1:0] mem [DEPTH];

    // The array has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Read-before-write: a read and write to the same address in one cycle
    // returns the old word, which is what the full-FIFO read+write case needs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/filtr_capture.sv
// rtl/filtr_capture.sv - filter result capture FIFO with sample counter and peak tracker
//
// Optional feature macro: FILTR_CAPTURE_PEAK_EN (enables the absolute-peak tracker;
// when undefined peak_abs is tied to zero).
//
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   data_in        filter result, captured on each filter_done rising edge
//   filter_done    completion flag, may be held high
//   clear          synchronous flush of FIFO, flags, counter and peak
//   rd_en          read request
//   rd_data        registered read word, qualified by rd_valid
//   rd_valid       one-cycle pulse per accepted read
//   empty, full    FIFO status from count
//   count          number of stored words
//   overflow       sticky dropped-sample flag
//   sample_cnt     filter_done rising edges seen, wrapping
//   peak_abs       largest absolute sample seen
module filtr_capture
    import filtr_pkg::*;
#(
    parameter  int DATA_SIZE = FILTR_DATA_SIZE,
    parameter  int DEPTH     = 64,
    localparam int ADDR_SIZE = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_SIZE-1:0]       data_in,
    input  logic                       filter_done,
    input  logic                       clear,
    input  logic                       rd_en,
    output logic [DATA_SIZE-1:0]       rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic                       full,
    output logic [ADDR_SIZE:0]         count,
    output logic                       overflow,
    output logic [SAMPLE_CNT_SIZE-1:0] sample_cnt,
    output logic [DATA_SIZE-1:0]       peak_abs
);

    logic                 done_q;
    logic                 wr_req;
    logic                 wr_ok;
    logic                 rd_ok;
    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;

    assign empty  = (count == '0);
    assign full   = (count == (ADDR_SIZE+1)'(DEPTH));
    assign wr_req = filter_done & ~done_q;

    // A read while full frees the slot the write lands in, so the write
    // is accepted; a read while empty is ignored even if a write arrives.
    assign rd_ok  = rd_en & ~empty & ~clear;
    assign wr_ok  = wr_req & (~full | rd_en) & ~clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rd_valid   <= 1'b0;
            overflow   <= 1'b0;
            sample_cnt <= '0;
        end else begin
            // Tracks the level even during clear so a held flag cannot re-trigger.
            done_q <= filter_done;
            if (clear) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                rd_valid   <= 1'b0;
                overflow   <= 1'b0;
                sample_cnt <= '0;
            end else begin
                rd_valid <= rd_ok;
                if (wr_ok)
                    wr_ptr <= wr_ptr + 1'b1;
                if (rd_ok)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({wr_ok, rd_ok})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                if (wr_req && !wr_ok)
                    overflow <= 1'b1;
                if (wr_req)
                    sample_cnt <= sample_cnt + 1'b1;
            end
        end
    end

`ifdef FILTR_CAPTURE_PEAK_EN
    logic signed [SAT_ABS_W-1:0] data_ext;
    logic [DATA_SIZE-1:0]        abs_val;

    assign data_ext = SAT_ABS_W'(signed'(data_in));
    assign abs_val  = DATA_SIZE'(sat_abs(data_ext, DATA_SIZE));

    // Dropped samples still count toward the peak.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            peak_abs <= '0;
        else if (clear)
            peak_abs <= '0;
        else if (wr_req && (abs_val > peak_abs))
            peak_abs <= abs_val;
    end
`else
    assign peak_abs = '0;
`endif

    filtr_capture_mem #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_filtr_capture.sv
// tb/tb_filtr_capture.sv - self-checking bench for filtr_capture
module tb_filtr_capture;

    localparam int DW    = 24;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          filter_done;
    logic          clear;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic [6:0]    count;
    logic          overflow;
    logic [15:0]   sample_cnt;
    logic [DW-1:0] peak_abs;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic          m_ov;
    logic [15:0]   m_sc;
    logic [DW-1:0] m_pk;
    logic          m_rv;
    logic [DW-1:0] m_rd;
    logic          m_done;

    filtr_capture dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .filter_done (filter_done),
        .clear       (clear),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overflow    (overflow),
        .sample_cnt  (sample_cnt),
        .peak_abs    (peak_abs)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_abs(input logic [DW-1:0] d);
        int v;
        v = int'(signed'(d));
        if (v < 0) v = -v;
        if (v > 8388607) v = 8388607;
        return DW'(v);
    endfunction

    task automatic model_reset();
        q.delete();
        m_ov = 0; m_sc = 0; m_pk = 0; m_rv = 0; m_rd = 0; m_done = 0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return #1 after it.
    task automatic step(input logic fd, input logic [DW-1:0] d, input logic rd, input logic clr);
        logic wr_req, rd_ok, wr_ok;
        filter_done = fd; data_in = d; rd_en = rd; clear = clr;
        @(posedge clk);
        wr_req = fd && !m_done;
        m_done = fd;
        if (clr) begin
            q.delete();
            m_ov = 0; m_sc = 0; m_pk = 0; m_rv = 0;
        end else begin
            rd_ok = rd && (q.size() > 0);
            wr_ok = wr_req && ((q.size() < DEPTH) || rd);
            m_rv  = rd_ok;
            if (rd_ok) m_rd = q.pop_front();
            if (wr_ok) q.push_back(d);
            if (wr_req && !wr_ok) m_ov = 1;
            if (wr_req) begin
                m_sc = m_sc + 1;
`ifdef FILTR_CAPTURE_PEAK_EN
                if (ref_abs(d) > m_pk) m_pk = ref_abs(d);
`endif
            end
        end
        #1;
    endtask

    task automatic pulse(input logic [DW-1:0] d);
        step(1, d, 0, 0);
        step(0, d, 0, 0);
    endtask

    task automatic test_reset();
        checks++; if (rd_data !== 0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        checks++; if (rd_valid !== 0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        checks++; if (count !== 0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (empty !== 1 || full !== 0) begin errors++; $display("FAIL reset_flags got empty=%b full=%b want 1 0", empty, full); end
        checks++; if (overflow !== 0 || sample_cnt !== 0 || peak_abs !== 0) begin
            errors++; $display("FAIL reset_misc got ov=%b sc=%0d pk=%h want 0 0 0", overflow, sample_cnt, peak_abs);
        end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] vals[3];
        vals[0] = 24'h000010; vals[1] = 24'hFFFFF0; vals[2] = 24'h7FFFFF;
        for (int i = 0; i < 3; i++) pulse(vals[i]);
        checks++; if (count !== 3) begin errors++; $display("FAIL wr_count got %0d want 3", count); end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0);
            checks++; if (rd_valid !== 1 || rd_data !== vals[i]) begin
                errors++; $display("FAIL wr_read%0d got v=%b d=%h want 1 %h", i, rd_valid, rd_data, vals[i]);
            end
        end
        step(0, 0, 0, 0);
        checks++; if (rd_valid !== 0) begin errors++; $display("FAIL wr_valid_pulse got %b want 0", rd_valid); end
        checks++; if (empty !== 1 || sample_cnt !== 3) begin
            errors++; $display("FAIL wr_after got empty=%b sc=%0d want 1 3", empty, sample_cnt);
        end
    endtask

    task automatic test_level_held();
        step(0, 0, 0, 1);
        for (int i = 0; i < 20; i++) step(1, 24'h123456, 0, 0);
        step(0, 0, 0, 0);
        checks++; if (count !== 1 || sample_cnt !== 1) begin
            errors++; $display("FAIL level_held got count=%0d sc=%0d want 1 1", count, sample_cnt);
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] first;
        step(0, 0, 0, 1);
        first = DW'($urandom);
        pulse(first);
        for (int i = 1; i < 64; i++) pulse(DW'($urandom));
        checks++; if (full !== 1 || count !== 64) begin errors++; $display("FAIL ovf_full got full=%b count=%0d want 1 64", full, count); end
        checks++; if (overflow !== 0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow); end
        pulse(DW'($urandom));
        checks++; if (overflow !== 1 || count !== 64 || sample_cnt !== 65) begin
            errors++; $display("FAIL ovf_drop got ov=%b count=%0d sc=%0d want 1 64 65", overflow, count, sample_cnt);
        end
        step(1, DW'($urandom), 1, 0);
        checks++; if (rd_valid !== 1 || rd_data !== first) begin
            errors++; $display("FAIL ovf_rdwr_data got v=%b d=%h want 1 %h", rd_valid, rd_data, first);
        end
        step(0, 0, 0, 0);
        checks++; if (count !== 64 || sample_cnt !== 66) begin
            errors++; $display("FAIL ovf_rdwr_count got count=%0d sc=%0d want 64 66", count, sample_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] exp_q[$];
        step(0, 0, 0, 1);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 40; i++) begin
                logic [DW-1:0] d;
                d = DW'($urandom);
                exp_q.push_back(d);
                pulse(d);
            end
            for (int i = 0; i < 40; i++) begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                step(0, 0, 1, 0);
                checks++; if (rd_valid !== 1 || rd_data !== e) begin
                    errors++; $display("FAIL wrap_r%0d_%0d got v=%b d=%h want 1 %h", r, i, rd_valid, rd_data, e);
                end
            end
        end
        step(0, 0, 0, 0);
        checks++; if (overflow !== 0 || full !== 0 || empty !== 1) begin
            errors++; $display("FAIL wrap_flags got ov=%b full=%b empty=%b want 0 0 1", overflow, full, empty);
        end
    endtask

    task automatic test_peak();
        logic [DW-1:0] ins[3];
        logic [DW-1:0] exp[3];
        ins[0] = 24'h000100; ins[1] = 24'hFFF000; ins[2] = 24'h800000;
`ifdef FILTR_CAPTURE_PEAK_EN
        exp[0] = 24'h000100; exp[1] = 24'h001000; exp[2] = 24'h7FFFFF;
`else
        exp[0] = 0; exp[1] = 0; exp[2] = 0;
`endif
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            pulse(ins[i]);
            checks++; if (peak_abs !== exp[i]) begin errors++; $display("FAIL peak%0d got %h want %h", i, peak_abs, exp[i]); end
        end
    endtask

    task automatic test_clear();
        pulse(24'h000ABC);
        step(1, 24'h000DEF, 0, 1);
        checks++; if (count !== 0 || sample_cnt !== 0 || empty !== 1) begin
            errors++; $display("FAIL clear_wr got count=%0d sc=%0d empty=%b want 0 0 1", count, sample_cnt, empty);
        end
        step(1, 24'h000DEF, 0, 0);
        step(0, 0, 0, 0);
        checks++; if (count !== 0 || sample_cnt !== 0) begin
            errors++; $display("FAIL clear_held got count=%0d sc=%0d want 0 0", count, sample_cnt);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            logic fd, rd, clr;
            fd  = ($urandom_range(0, 1) == 1);
            rd  = (c < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 199) == 0);
            step(fd, DW'($urandom), rd, clr);
            checks++; if (count !== 7'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin
                errors++; $display("FAIL rnd_count c=%0d got %0d e=%b f=%b want %0d", c, count, empty, full, q.size());
            end
            checks++; if (rd_valid !== m_rv || rd_data !== m_rd) begin
                errors++; $display("FAIL rnd_read c=%0d got v=%b d=%h want %b %h", c, rd_valid, rd_data, m_rv, m_rd);
            end
            checks++; if (overflow !== m_ov || sample_cnt !== m_sc || peak_abs !== m_pk) begin
                errors++; $display("FAIL rnd_misc c=%0d got ov=%b sc=%0d pk=%h want %b %0d %h", c, overflow, sample_cnt, peak_abs, m_ov, m_sc, m_pk);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(0, 0, 0, 1);
        pulse(24'h055555);
        pulse(24'h0AAAAA);
        step(0, 0, 1, 0);
        checks++; if (rd_valid !== 1) begin errors++; $display("FAIL rstmid_pre got %b want 1", rd_valid); end
        reset = 1'b0;
        model_reset();
        #1;
        checks++; if (rd_valid !== 0 || empty !== 1 || count !== 0 || rd_data !== 0) begin
            errors++; $display("FAIL rstmid got v=%b e=%b c=%0d d=%h want 0 1 0 0", rd_valid, empty, count, rd_data);
        end
        #1 reset = 1'b1;
        step(0, 0, 1, 0);
        checks++; if (rd_valid !== 0 || empty !== 1) begin
            errors++; $display("FAIL rstmid_after got v=%b e=%b want 0 1", rd_valid, empty);
        end
    endtask

    initial begin
        reset = 1'b0; filter_done = 0; data_in = 0; clear = 0; rd_en = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        #2 reset = 1'b1;
        test_write_read();
        test_level_held();
        test_overflow();
        test_wrap();
        test_peak();
        test_clear();
        step(0, 0, 0, 1);
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
